tx_burst_sequencer: RTL and testbench



---
 rtl/tx_seq_pkg.sv | 7 +
 rtl/tx_guard_timer.sv | 18 +
 rtl/tx_burst_sequencer.sv | 139 +++++++++++++
 tb/tb_tx_burst_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// tx_seq_pkg: shared FSM state encoding and default widths for the TX burst sequencer.
package tx_seq_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int SIZE_W_DEF  = 8;
  localparam int GUARD_W_DEF = 32;
  typedef enum logic [2:0] {IDLE, GUARD, FETCH, WAIT_DATA, SEND, DONE} state_t;
endpackage

// File: rtl/tx_guard_timer.sv
// tx_guard_timer: loadable down-counter with a zero flag; saturates at zero.
module tx_guard_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero = cnt_q == '0;
endmodule

// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer: drains a latched-length burst from the TX FIFO to the transmitter after a guard delay.
// Optional abort input and sticky aborted flag are built when TX_BURST_ABORT_EN is defined.
module tx_burst_sequencer
  import tx_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SIZE_W  = SIZE_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [GUARD_W-1:0] guard_interval,
  input  logic [SIZE_W-1:0]  fifo_size,
  input  logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_rden,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [SIZE_W-1:0]  byte_count,
  output logic               done_irq,
  input  logic               irq_ack,
`ifdef TX_BURST_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               err_empty
);
  state_t state_q, state_d;
  logic [SIZE_W-1:0] rem_q, rem_d, byte_count_q, byte_count_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic rden_q, rden_d, tx_valid_q, tx_valid_d, busy_q, busy_d;
  logic done_q, done_d, err_q, err_d, done_set, load, dec, guard_zero;
`ifdef TX_BURST_ABORT_EN
  logic aborted_q, aborted_d, abort_hit;
`endif
  tx_guard_timer #(.W(GUARD_W)) u_guard (
    .clk(clk), .reset(reset), .load(load), .dec(dec),
    .load_val(guard_interval), .zero(guard_zero)
  );
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    byte_count_d = byte_count_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    rden_d       = 1'b0;
    err_d        = 1'b0;
    done_set     = 1'b0;
    load         = 1'b0;
    dec          = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (fifo_size != '0) begin
          state_d      = GUARD;
          rem_d        = fifo_size;
          byte_count_d = '0;
          load         = 1'b1;
        end else err_d = 1'b1;
      end
      GUARD: if (guard_zero) begin
        state_d = FETCH;
        rden_d  = 1'b1;
      end else dec = 1'b1;
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        tx_data_d  = fifo_data;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: if (tx_ready) begin
        tx_valid_d   = 1'b0;
        byte_count_d = byte_count_q + SIZE_W'(1);
        rem_d        = rem_q - SIZE_W'(1);
        state_d      = (rem_q == SIZE_W'(1)) ? DONE : FETCH;
        rden_d       = rem_q != SIZE_W'(1);
      end
      DONE: begin
        done_set = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TX_BURST_ABORT_EN
    abort_hit = abort && state_q != IDLE;
    if (abort_hit) begin
      state_d      = IDLE;
      rden_d       = 1'b0;
      tx_valid_d   = 1'b0;
      byte_count_d = byte_count_q;
      rem_d        = rem_q;
      done_set     = 1'b0;
      dec          = 1'b0;
    end
    aborted_d = abort_hit | (aborted_q & ~irq_ack);
`endif
    busy_d = state_d != IDLE;
    done_d = done_set | (done_q & ~irq_ack);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      byte_count_q <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rden_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef TX_BURST_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      byte_count_q <= byte_count_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      rden_q       <= rden_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef TX_BURST_ABORT_EN
      aborted_q    <= aborted_d;
`endif
    end
  assign fifo_rden  = rden_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign byte_count = byte_count_q;
  assign done_irq   = done_q;
  assign err_empty  = err_q;
`ifdef TX_BURST_ABORT_EN
  assign aborted    = aborted_q;
`endif
endmodule

// File: tb/tb_tx_burst_sequencer.sv
// tb_tx_burst_sequencer: directed bench with a FIFO model and a byte scoreboard for tx_burst_sequencer.
module tb_tx_burst_sequencer;
  logic clk = 0, reset = 0, start = 0, tx_ready = 1, irq_ack = 0;
  logic [31:0] guard_interval = 0;
  logic [7:0] fifo_size = 0, fifo_data = 0, tx_data, byte_count;
  logic fifo_rden, tx_valid, busy, done_irq, err_empty;
`ifdef TX_BURST_ABORT_EN
  logic abort = 0, aborted;
`endif
  int total = 0, passed = 0, rden_cnt = 0, r0;
  logic [7:0] fifo_mem[$], exp_q[$], held;

  tx_burst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .guard_interval(guard_interval),
    .fifo_size(fifo_size), .fifo_data(fifo_data), .fifo_rden(fifo_rden),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .byte_count(byte_count), .done_irq(done_irq), .irq_ack(irq_ack),
`ifdef TX_BURST_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .err_empty(err_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_burst(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      fifo_mem.push_back(b);
      exp_q.push_back(b);
    end
    fifo_size = 8'(n);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) chk(tag, 0, 1);
  endtask

  // FIFO model: read data appears the cycle after the strobe
  initial forever begin
    logic [7:0] r;
    @(posedge clk);
    if (fifo_rden === 1'b1 && !reset) begin
      r = fifo_mem.size() != 0 ? fifo_mem.pop_front() : 8'hEE;
      #1 fifo_data = r;
    end
  end

  // scoreboard: every handshake pops the next expected byte
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (fifo_rden === 1'b1) rden_cnt++;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("sb_extra_byte", {56'd0, tx_data}, 64'hFFFF);
        else chk("sb_tx_data", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2 reset = 1;
    #1 chk("reset_outputs", {fifo_rden, tx_valid, busy, done_irq, err_empty, tx_data, byte_count}, 0);
    tick();
    tick();
    reset = 0;
    tick();

    // 3-byte burst, guard 4, ready tied high
    guard_interval = 4;
    load_burst(3);
    r0 = rden_cnt;
    start = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = 0;
      chk($sformatf("a_rden_c%0d", c), fifo_rden, c == 6 || c == 9 || c == 12);
      chk($sformatf("a_valid_c%0d", c), tx_valid, c == 8 || c == 11 || c == 14);
      chk($sformatf("a_busy_c%0d", c), busy, c <= 15);
      chk($sformatf("a_done_c%0d", c), done_irq, c == 16);
    end
    chk("a_byte_count", byte_count, 3);
    chk("a_rden_total", rden_cnt - r0, 3);
    chk("a_sb_empty", exp_q.size(), 0);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("a_ack_clears", done_irq, 0);

    // empty FIFO start
    fifo_size = 0;
    r0 = rden_cnt;
    start = 1;
    tick();
    start = 0;
    chk("e_err_pulse", err_empty, 1);
    chk("e_busy", busy, 0);
    tick();
    chk("e_err_one_cycle", err_empty, 0);
    tick();
    tick();
    chk("e_no_rden", rden_cnt - r0, 0);
    chk("e_busy_after", busy, 0);

    // 2 bytes with a 5-cycle back-pressure stall on the first
    guard_interval = 1;
    load_burst(2);
    r0 = rden_cnt;
    tx_ready = 0;
    start = 1;
    tick();
    start = 0;
    wait_valid("s_valid_timeout");
    held = tx_data;
    for (int c = 0; c < 5; c++) begin
      chk("s_valid_hold", tx_valid, 1);
      chk("s_data_hold", tx_data, held);
      tick();
    end
    tx_ready = 1;
    wait_idle("s_idle_timeout");
    chk("s_rden_total", rden_cnt - r0, 2);
    chk("s_byte_count", byte_count, 2);
    chk("s_done", done_irq, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;

    // zero guard, single byte, a second start mid-burst is ignored
    guard_interval = 0;
    load_burst(1);
    r0 = rden_cnt;
    start = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = c == 2;
      fifo_size = c == 2 ? 8'd5 : 8'd1;
      if (c == 3 || c == 4) chk($sformatf("g_valid_c%0d", c), tx_valid, c == 4);
    end
    chk("g_done", done_irq, 1);
    chk("g_byte_count", byte_count, 1);
    for (int c = 0; c < 6; c++) tick();
    chk("g_no_second_burst", busy, 0);
    chk("g_rden_total", rden_cnt - r0, 1);
    // done set and irq_ack in the same cycle: set wins
    load_burst(1);
    start = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 0;
    end
    chk("g_in_done_state", busy, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("g_set_wins", done_irq, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("g_ack_after", done_irq, 0);

    // asynchronous reset during SEND of byte 2 of 4
    load_burst(4);
    tx_ready = 0;
    start = 1;
    tick();
    start = 0;
    wait_valid("r_valid1_timeout");
    tx_ready = 1;
    tick();
    tx_ready = 0;
    wait_valid("r_valid2_timeout");
    chk("r_count_before", byte_count, 1);
    #2 reset = 1;
    #1 chk("r_async_clear", {fifo_rden, tx_valid, busy, done_irq, err_empty, tx_data, byte_count}, 0);
    fifo_mem.delete();
    exp_q.delete();
    r0 = rden_cnt;
    tick();
    tick();
    chk("r_no_rden_in_reset", fifo_rden, 0);
    reset = 0;
    tx_ready = 1;
    tick();
    load_burst(1);
    start = 1;
    tick();
    start = 0;
    chk("r_fresh_count", byte_count, 0);
    chk("r_fresh_busy", busy, 1);
    wait_idle("r_idle_timeout");
    chk("r_fresh_done_count", byte_count, 1);
    chk("r_fresh_rden", rden_cnt - r0, 1);
    irq_ack = 1;
    tick();
    irq_ack = 0;

`ifdef TX_BURST_ABORT_EN
    guard_interval = 5;
    load_burst(2);
    r0 = rden_cnt;
    start = 1;
    tick();
    start = 0;
    tick();
    abort = 1;
    tick();
    abort = 0;
    chk("x_busy", busy, 0);
    chk("x_aborted", aborted, 1);
    chk("x_done", done_irq, 0);
    for (int c = 0; c < 10; c++) tick();
    chk("x_no_rden", rden_cnt - r0, 0);
    chk("x_byte_count", byte_count, 0);
    fifo_mem.delete();
    exp_q.delete();
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("x_ack_clears", aborted, 0);
`endif

    chk("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
